// File: rtl/led_matrix_scanner.sv
// Row-scanning driver for an 8x8 LED matrix with blanking between rows and frame-aligned
// pattern latching. Define MATRIX_BLINK_EN to blink the caution pattern every BLINK_FRAMES frames.
module led_matrix_scanner #(
    parameter int unsigned BLANK_CYCLES = 2,
    parameter int unsigned BLINK_FRAMES = 64
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       scan_tick_i,
    input  logic [1:0] pattern_i,
    output logic [7:0] row_o,
    output logic [7:0] col_o,
    output logic       frame_start_o
);

    typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

    if (BLANK_CYCLES > 15 || BLINK_FRAMES == 0) begin : g_param_check
        $error("led_matrix_scanner: BLANK_CYCLES must be 0..15 and BLINK_FRAMES at least 1");
    end

    state_e     state_q, state_d;
    logic [2:0] row_idx_q, row_idx_d;
    logic [1:0] pat_q, pat_d;
    logic [3:0] blank_cnt_q, blank_cnt_d;
    logic [7:0] row_d, col_d;
    logic       frame_start_d;
    logic       advance;
    logic       blink_off;

    function automatic logic [7:0] rom_lit(input logic [1:0] code, input logic [2:0] idx);
        case (code)
            2'd0:    rom_lit = (8'd1 << idx) | (8'd1 << (3'd7 - idx));
            2'd1:    rom_lit = 8'hFF;
            2'd2:    rom_lit = (idx == 3'd0 || idx == 3'd7) ? 8'hFF : 8'h81;
            default: rom_lit = 8'h00;
        endcase
    endfunction

    always_comb begin
        state_d       = state_q;
        row_idx_d     = row_idx_q;
        pat_d         = pat_q;
        blank_cnt_d   = blank_cnt_q;
        frame_start_d = 1'b0;
        advance       = 1'b0;

        case (state_q)
            StIdle: begin
                if (scan_tick_i) begin
                    pat_d         = pattern_i;
                    row_idx_d     = 3'd0;
                    state_d       = StDrive;
                    frame_start_d = 1'b1;
                end
            end
            StDrive: begin
                if (scan_tick_i) begin
                    if (BLANK_CYCLES > 0) begin
                        state_d     = StBlank;
                        blank_cnt_d = 4'(BLANK_CYCLES - 1);
                    end else begin
                        advance = 1'b1;
                    end
                end
            end
            StBlank: begin
                blank_cnt_d = blank_cnt_q - 4'd1;
                if (blank_cnt_q == 4'd0) begin
                    blank_cnt_d = 4'd0;
                    state_d     = StDrive;
                    advance     = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // Pattern is re-sampled only when wrapping to row 0, so a frame never tears.
        if (advance) begin
            if (row_idx_q == 3'd7) begin
                row_idx_d     = 3'd0;
                pat_d         = pattern_i;
                frame_start_d = 1'b1;
            end else begin
                row_idx_d = row_idx_q + 3'd1;
            end
        end
    end

`ifdef MATRIX_BLINK_EN
    localparam int unsigned CntW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CntW-1:0] frame_cnt_q, frame_cnt_d;
    logic            phase_q, phase_d;

    // The IDLE-exit pulse starts frame 0, so only row-7 wraps count frames.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        phase_d     = phase_q;
        if (advance && row_idx_q == 3'd7) begin
            if (frame_cnt_q == CntW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                phase_d     = ~phase_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            frame_cnt_q <= '0;
            phase_q     <= 1'b0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            phase_q     <= phase_d;
        end
    end

    assign blink_off = (pat_d == 2'd2) && phase_d;
`else
    assign blink_off = 1'b0;
`endif

    always_comb begin
        row_d = 8'h00;
        col_d = 8'hFF;
        if (state_d == StDrive) begin
            row_d = 8'd1 << row_idx_d;
            col_d = blink_off ? 8'hFF : ~rom_lit(pat_d, row_idx_d);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            row_idx_q     <= 3'd0;
            pat_q         <= 2'd3;
            blank_cnt_q   <= 4'd0;
            row_o         <= 8'h00;
            col_o         <= 8'hFF;
            frame_start_o <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_idx_q     <= row_idx_d;
            pat_q         <= pat_d;
            blank_cnt_q   <= blank_cnt_d;
            row_o         <= row_d;
            col_o         <= col_d;
            frame_start_o <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Scoreboard bench: two scanners (0 and 2 blanking cycles) share stimulus; a frame-level
// reference model queues the expected outputs and a negedge monitor compares them.
module tb_led_matrix_scanner;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic       fs;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       scan_tick;
    logic [1:0] pattern;
    logic [7:0] row0, col0, row2, col2;
    logic       fs0, fs2;

    exp_t q0[$];
    exp_t q1[$];
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    led_matrix_scanner #(.BLANK_CYCLES(0), .BLINK_FRAMES(2)) u_dut_b0 (
        .clk_i(clk), .rst_ni(rst_n), .scan_tick_i(scan_tick), .pattern_i(pattern),
        .row_o(row0), .col_o(col0), .frame_start_o(fs0)
    );

    led_matrix_scanner #(.BLANK_CYCLES(2), .BLINK_FRAMES(2)) u_dut_b2 (
        .clk_i(clk), .rst_ni(rst_n), .scan_tick_i(scan_tick), .pattern_i(pattern),
        .row_o(row2), .col_o(col2), .frame_start_o(fs2)
    );

    // Lit columns from the pattern descriptions, one column at a time.
    function automatic logic [7:0] ref_lit(input int code, input int r);
        logic [7:0] lit;
        lit = 8'h00;
        for (int j = 0; j < 8; j++) begin
            case (code)
                0:       lit[j] = (j == r) || (j == 7 - r);
                1:       lit[j] = 1'b1;
                2:       lit[j] = (r == 0) || (r == 7) || (j == 0) || (j == 7);
                default: lit[j] = 1'b0;
            endcase
        end
        return lit;
    endfunction

    int m_row[2];
    bit m_show[2];
    int m_gap[2];
    int m_pat[2];
    int m_frame[2];

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_row[k] = -1; m_show[k] = 0; m_gap[k] = 0; m_pat[k] = 3; m_frame[k] = -1;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                int   b;
                bit   fs;
                bit   adv;
                exp_t e;
                b   = (k == 0) ? 0 : 2;
                fs  = 0;
                adv = 0;
                if (!rst_n) begin
                    m_row[k] = -1; m_show[k] = 0; m_gap[k] = 0; m_pat[k] = 3; m_frame[k] = -1;
                end else if (m_row[k] < 0) begin
                    if (scan_tick) begin
                        m_row[k] = 0; m_pat[k] = int'(pattern); m_show[k] = 1; fs = 1;
                    end
                end else if (m_show[k]) begin
                    if (scan_tick) begin
                        if (b == 0) adv = 1;
                        else begin
                            m_show[k] = 0;
                            m_gap[k]  = b;
                        end
                    end
                end else begin
                    m_gap[k] = m_gap[k] - 1;
                    if (m_gap[k] == 0) begin
                        adv       = 1;
                        m_show[k] = 1;
                    end
                end
                if (adv) begin
                    if (m_row[k] == 7) begin
                        m_row[k] = 0; m_pat[k] = int'(pattern); fs = 1;
                    end else begin
                        m_row[k] = m_row[k] + 1;
                    end
                end
                if (fs) m_frame[k] = m_frame[k] + 1;
                e.fs  = fs;
                e.row = m_show[k] ? 8'(1 << m_row[k]) : 8'h00;
                e.col = m_show[k] ? ~ref_lit(m_pat[k], m_row[k]) : 8'hFF;
`ifdef MATRIX_BLINK_EN
                if (m_show[k] && m_pat[k] == 2 && ((m_frame[k] / 2) % 2) == 1) e.col = 8'hFF;
`endif
                if (k == 0) q0.push_back(e);
                else        q1.push_back(e);
            end
        end
    end

    task automatic check(input string nm, input logic [7:0] r, input logic [7:0] c,
                         input logic f, input exp_t e);
        n_checks++;
        if (r !== e.row || c !== e.col || f !== e.fs) begin
            n_errors++;
            $display("FAIL %s t=%0t row got %h exp %h col got %h exp %h frame_start got %b exp %b",
                     nm, $time, r, e.row, c, e.col, f, e.fs);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                e = q0.pop_front();
                check("dut_b0", row0, col0, fs0, e);
            end
            if (q1.size() > 0) begin
                e = q1.pop_front();
                check("dut_b2", row2, col2, fs2, e);
            end
        end
    end

    task automatic cyc(input logic r, input logic t, input logic [1:0] p);
        rst_n     = r;
        scan_tick = t;
        pattern   = p;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [1:0] p;
        int         gap;
        p = 2'd0;
        // Reset held, then idle with no ticks.
        repeat (3) cyc(1'b0, 1'b0, 2'd0);
        repeat (6) cyc(1'b1, 1'b0, 2'd0);
        // Stop pattern, nine slow ticks: a full frame plus the next frame start.
        repeat (9) begin
            repeat (19) cyc(1'b1, 1'b0, 2'd0);
            cyc(1'b1, 1'b1, 2'd0);
        end
        // Caution pattern with blanking gaps.
        repeat (4) begin
            repeat (5) cyc(1'b1, 1'b0, 2'd2);
            cyc(1'b1, 1'b1, 2'd2);
        end
        // Full pattern, switched to blank mid-frame.
        for (int i = 0; i < 16; i++) begin
            p = (i >= 4) ? 2'd3 : 2'd1;
            repeat (5) cyc(1'b1, 1'b0, p);
            cyc(1'b1, 1'b1, p);
        end
        // Reset while the blanking scanner is between rows.
        cyc(1'b1, 1'b1, 2'd0);
        cyc(1'b1, 1'b0, 2'd0);
        cyc(1'b0, 1'b0, 2'd0);
        repeat (4) cyc(1'b1, 1'b0, 2'd0);
        cyc(1'b1, 1'b1, 2'd0);
        repeat (6) cyc(1'b1, 1'b0, 2'd0);
        // Random ticks, pattern changes and occasional resets.
        repeat (500) begin
            gap = $urandom_range(3, 14);
            repeat (gap) begin
                if ($urandom_range(0, 7) == 0) p = 2'($urandom);
                cyc(1'b1, 1'b0, p);
            end
            if ($urandom_range(0, 49) == 0) cyc(1'b0, 1'b0, p);
            else                            cyc(1'b1, 1'b1, p);
        end
        repeat (4) cyc(1'b1, 1'b0, p);
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
